ad_acq_ctrl: RTL and testbench
==============================

Name: ad_acq_ctrl

Overview:
Parametrised multi-channel ADC acquisition controller. Runs from the single system clock. On a burst trigger it waits a programmable pre-sample delay, then generates a registered, divided ADC clock and a per-sample write strobe for a programmed number of samples. It drives per-channel ADC output enables and signals completion to the upstream FIFO/readout logic.

Parameters:
NCH, 2, number of ADC channels (per-channel enable/OE_N)
DIV_W, 8, width of clock divider setting
LEN_W, 32, width of sample-count setting
DLY_W, 16, width of pre-sample delay setting

Ports:
clk  in  1  system clock, 100 MHz
reset_n  in  1  asynchronous active-low reset
burst_syn  in  1  trigger level; acquisition starts on its rising edge
abort  in  1  synchronous abort, returns to IDLE
cfg_div  in  DIV_W  ADC clock divide ratio; values 0,1,2 all mean 2
cfg_len  in  LEN_W  samples per burst; 0 means no sampling, done pulse only
cfg_dly  in  DLY_W  clk cycles from trigger to first ADC clock period
cfg_ch_en  in  NCH  channel enable mask
AD_clk  out  1  registered divided ADC clock, low when idle
AD_OE_N  out  NCH  per-channel output enable, active low
AD_PDWN  out  1  constant 0
sample_strobe  out  1  one-cycle pulse per captured sample (FIFO write)
sample_cnt  out  LEN_W  samples completed in current burst
busy  out  1  high in DELAY or SAMPLE
done  out  1  one-cycle pulse at end of burst or on abort

Behaviour:
- Reset (async, reset_n=0): state IDLE; AD_clk=0, AD_OE_N=all 1, sample_strobe=0, sample_cnt=0, busy=0, done=0, internal counters 0, syn_d=0.
- Trigger: syn_d registers burst_syn. Rising edge = burst_syn & ~syn_d, evaluated only in IDLE. cfg_div (after clamp), cfg_len, cfg_dly, cfg_ch_en are latched on that edge. Config changes during a burst have no effect.
- States: IDLE, DELAY, SAMPLE, QUIT.
- IDLE -> DELAY on trigger edge when latched dly>0; -> SAMPLE directly when dly=0; -> QUIT with done pulse next cycle when len=0.
- DELAY: delay counter counts 0..dly-1, then -> SAMPLE. First AD_clk rising edge occurs exactly dly+1 cycles after the trigger edge cycle.
- SAMPLE: div counter d counts 0..D-1 and wraps, where D is the latched clamped divide ratio.
  - AD_clk <= (d < D/2), integer divide. High for floor(D/2) cycles per period. Registered, so glitch-free.
  - sample_strobe asserts for one cycle when d=D-1; sample_cnt increments on the same edge.
  - When sample_cnt reaches len (final strobe), -> QUIT and done=1 for one cycle. AD_clk is forced low and d resets.
- AD_OE_N[i] = ~(busy & ch_en_latched[i]), registered.
- QUIT: stays until burst_syn=0, then -> IDLE. A trigger held high never retriggers.
- abort: has priority over all transitions. From DELAY or SAMPLE it goes to QUIT with done=1, AD_clk=0, and strobe suppressed that cycle. In IDLE or QUIT it is ignored.
- sample_cnt holds its final value until the next trigger edge clears it.
- Counters never wrap mid-burst, because len is bounded by the LEN_W range. A len of all-ones is legal.
- Reset asserted mid-burst returns to the reset state immediately; no done pulse.

Decomposition:
- Package ad_acq_pkg: state enum (IDLE, DELAY, SAMPLE, QUIT), the DIV_MIN=2 constant, and the divider clamp function.
- One natural sub-module, ad_clk_div: latched ratio, counter, registered AD_clk, and end-of-period strobe. It has an enable/clear input.

Test Plan:
- Reset then idle: cfg_div=4, cfg_len=8, cfg_dly=0, no trigger -> AD_clk=0, AD_OE_N=2'b11, busy=0, no strobes.
- Basic burst: div=4, len=8, dly=0, ch_en=2'b11, pulse burst_syn high for 50 cycles -> AD_clk high 2 cycles and low 2 cycles, 8 strobes 4 cycles apart, done once, sample_cnt=8, AD_OE_N=00 during busy. No retrigger while burst_syn stays high.
- Delay and odd divide: div=5, len=3, dly=10, ch_en=2'b01 -> first AD_clk rise 11 cycles after trigger, AD_clk high 2 and low 3, AD_OE_N=2'b10 while busy, 3 strobes.
- Divider clamp: div=0, then 1, len=4 -> each behaves as div=2, strobes every 2 cycles.
- Abort: div=4, len=100, abort asserted after 5 strobes -> done pulse, sample_cnt=5, AD_clk low next cycle, state QUIT until burst_syn low.
- len=0 and mid-burst reset: len=0 -> done pulse, no AD_clk or strobe. reset_n low during SAMPLE -> all outputs at reset values immediately, no done.

Source files
------------

// File: rtl/ad_acq_ctrl_pkg.sv
// Shared types and helpers for the ADC acquisition controller.
package ad_acq_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        SAMPLE = 2'd2,
        QUIT   = 2'd3
    } state_t;

    localparam int unsigned DIV_MIN = 2;

    // Divide ratios below DIV_MIN cannot produce a two-phase clock, so they saturate.
    function automatic int unsigned clamp_div(input int unsigned v);
        return (v < DIV_MIN) ? DIV_MIN : v;
    endfunction

endpackage

// File: rtl/ad_acq_ctrl_if.sv
// Bus between the upstream trigger/config logic and the acquisition controller.
interface ad_acq_ctrl_if
    import ad_acq_pkg::*;
#(
    parameter int NCH   = 2,
    parameter int DIV_W = 8,
    parameter int LEN_W = 32,
    parameter int DLY_W = 16
) ();

    // No valid/ready pair: burst_syn is a level whose rising edge starts one burst
    // while the controller is IDLE; cfg_* are sampled only on that edge; done is a
    // single-cycle completion pulse; sample_strobe qualifies one FIFO write per sample.
    logic             burst_syn;
    logic             abort;
    logic [DIV_W-1:0] cfg_div;
    logic [LEN_W-1:0] cfg_len;
    logic [DLY_W-1:0] cfg_dly;
    logic [NCH-1:0]   cfg_ch_en;

    logic             AD_clk;
    logic [NCH-1:0]   AD_OE_N;
    logic             AD_PDWN;
    logic             sample_strobe;
    logic [LEN_W-1:0] sample_cnt;
    logic             busy;
    logic             done;
    state_t           dbg_state;

    modport master (
        output burst_syn, abort, cfg_div, cfg_len, cfg_dly, cfg_ch_en,
        input  AD_clk, AD_OE_N, AD_PDWN, sample_strobe, sample_cnt, busy, done, dbg_state
    );

    modport slave (
        input  burst_syn, abort, cfg_div, cfg_len, cfg_dly, cfg_ch_en,
        output AD_clk, AD_OE_N, AD_PDWN, sample_strobe, sample_cnt, busy, done, dbg_state
    );

endinterface

// File: rtl/ad_acq_ctrl_clk_div.sv
// Registered ADC clock divider: high while the phase counter is in the first half
// of the period, with an end-of-period strobe.
module ad_clk_div
    import ad_acq_pkg::*;
#(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load_i,    // latch div_i as the ratio for the next run
    input  logic [DIV_W-1:0] div_i,
    input  logic             run_i,     // divider runs next cycle; low clears it
    input  logic             active_i,  // divider is running this cycle
    output logic             ad_clk_o,
    output logic             strobe_o
);

    logic [DIV_W-1:0] ratio_q, ratio_d;
    logic [DIV_W-1:0] d_q, d_d;
    logic             clk_q, clk_d;
    logic             last;

    assign last = (d_q == ratio_q - DIV_W'(1));

    always_comb begin
        ratio_d = load_i ? div_i : ratio_q;
        d_d     = d_q;
        clk_d   = clk_q;
        if (!run_i) begin
            d_d   = '0;
            clk_d = 1'b0;
        end else if (!active_i) begin
            // Phase 0 of the first period is always high since the ratio is at least 2.
            d_d   = '0;
            clk_d = 1'b1;
        end else begin
            d_d   = last ? '0 : d_q + DIV_W'(1);
            clk_d = (d_d < (ratio_q >> 1));
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ratio_q <= DIV_W'(DIV_MIN);
            d_q     <= '0;
            clk_q   <= 1'b0;
        end else begin
            ratio_q <= ratio_d;
            d_q     <= d_d;
            clk_q   <= clk_d;
        end
    end

    assign ad_clk_o = clk_q;
    assign strobe_o = active_i & last;

endmodule

// File: rtl/ad_acq_ctrl.sv
// Burst acquisition sequencer: trigger edge, pre-sample delay, divided ADC clock
// with per-sample strobes, then completion pulse.
module ad_acq_ctrl
    import ad_acq_pkg::*;
#(
    parameter int NCH   = 2,
    parameter int DIV_W = 8,
    parameter int LEN_W = 32,
    parameter int DLY_W = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    ad_acq_ctrl_if.slave bus
);

    state_t           state_q, state_d;
    logic             syn_d_q;
    logic [LEN_W-1:0] len_q, len_d;
    logic [DLY_W-1:0] dly_q, dly_d;
    logic [NCH-1:0]   ch_en_q, ch_en_d;
    logic [DLY_W-1:0] dly_cnt_q, dly_cnt_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;
    logic [NCH-1:0]   oe_n_q, oe_n_d;
    logic             strobe;
    logic             busy_d;
    logic             trig;
    logic             div_strobe;
    logic             div_clk;
    logic [DIV_W-1:0] div_c;

    assign trig  = (state_q == IDLE) & bus.burst_syn & ~syn_d_q;
    assign div_c = DIV_W'(clamp_div(32'(bus.cfg_div)));

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        dly_d     = dly_q;
        ch_en_d   = ch_en_q;
        dly_cnt_d = dly_cnt_q;
        cnt_d     = cnt_q;
        done_d    = 1'b0;
        strobe    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (trig) begin
                    len_d     = bus.cfg_len;
                    dly_d     = bus.cfg_dly;
                    ch_en_d   = bus.cfg_ch_en;
                    cnt_d     = '0;
                    dly_cnt_d = '0;
                    if (bus.cfg_len == '0) begin
                        state_d = QUIT;
                        done_d  = 1'b1;
                    end else if (bus.cfg_dly == '0) begin
                        state_d = SAMPLE;
                    end else begin
                        state_d = DELAY;
                    end
                end
            end
            DELAY: begin
                if (bus.abort) begin
                    state_d = QUIT;
                    done_d  = 1'b1;
                end else if (dly_cnt_q == dly_q - DLY_W'(1)) begin
                    state_d   = SAMPLE;
                    dly_cnt_d = '0;
                end else begin
                    dly_cnt_d = dly_cnt_q + DLY_W'(1);
                end
            end
            SAMPLE: begin
                if (bus.abort) begin
                    state_d = QUIT;
                    done_d  = 1'b1;
                end else if (div_strobe) begin
                    strobe = 1'b1;
                    cnt_d  = cnt_q + LEN_W'(1);
                    if (cnt_d == len_q) begin
                        state_d = QUIT;
                        done_d  = 1'b1;
                    end
                end
            end
            QUIT: begin
                if (!bus.burst_syn) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == DELAY) || (state_d == SAMPLE);
        oe_n_d = ~({NCH{busy_d}} & ch_en_d);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            syn_d_q   <= 1'b0;
            len_q     <= '0;
            dly_q     <= '0;
            ch_en_q   <= '0;
            dly_cnt_q <= '0;
            cnt_q     <= '0;
            done_q    <= 1'b0;
            oe_n_q    <= '1;
        end else begin
            state_q   <= state_d;
            syn_d_q   <= bus.burst_syn;
            len_q     <= len_d;
            dly_q     <= dly_d;
            ch_en_q   <= ch_en_d;
            dly_cnt_q <= dly_cnt_d;
            cnt_q     <= cnt_d;
            done_q    <= done_d;
            oe_n_q    <= oe_n_d;
        end
    end

    ad_clk_div #(.DIV_W(DIV_W)) u_clk_div (
        .clk      (clk),
        .reset_n  (reset_n),
        .load_i   (trig),
        .div_i    (div_c),
        .run_i    (state_d == SAMPLE),
        .active_i (state_q == SAMPLE),
        .ad_clk_o (div_clk),
        .strobe_o (div_strobe)
    );

    assign bus.AD_clk        = div_clk;
    assign bus.AD_OE_N       = oe_n_q;
    assign bus.AD_PDWN       = 1'b0;
    assign bus.sample_strobe = strobe;
    assign bus.sample_cnt    = cnt_q;
    assign bus.busy          = (state_q == DELAY) || (state_q == SAMPLE);
    assign bus.done          = done_q;
    assign bus.dbg_state     = state_q;

endmodule

// File: tb/tb_ad_acq_ctrl.sv
// Directed bench for ad_acq_ctrl: bursts with hand-derived cycle timing.
module tb_ad_acq_ctrl;
  import ad_acq_pkg::*;

  logic clk;
  logic reset_n;
  int   vectors;
  int   miscompares;

  ad_acq_ctrl_if #(.NCH(2), .DIV_W(8), .LEN_W(32), .DLY_W(16)) bus ();

  ad_acq_ctrl #(.NCH(2), .DIV_W(8), .LEN_W(32), .DLY_W(16)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Raise the trigger and check every cycle k after the trigger-edge cycle.
  // Sampling starts at k=dly+1; sample j of the run sits at j=k-(dly+1).
  task automatic run_burst(input string name, input int raw_div, input int d_eff,
                           input int len, input int dly, input logic [1:0] ch,
                           input int ncyc);
    int s;
    int total;
    int j;
    logic e_clk, e_str, e_done, e_busy;
    logic [1:0] e_oe;
    logic [31:0] e_cnt;
    bus.cfg_div   = 8'(raw_div);
    bus.cfg_len   = 32'(len);
    bus.cfg_dly   = 16'(dly);
    bus.cfg_ch_en = ch;
    bus.burst_syn = 1'b1;
    s     = dly + 1;
    total = len * d_eff;
    for (int k = 1; k <= ncyc; k++) begin
      tick();
      if (k == 2) begin
        bus.cfg_div   = 8'($urandom_range(0, 255));
        bus.cfg_len   = $urandom;
        bus.cfg_dly   = 16'($urandom_range(0, 65535));
        bus.cfg_ch_en = 2'($urandom_range(0, 3));
      end
      e_clk = 1'b0; e_str = 1'b0; e_done = 1'b0; e_busy = 1'b0; e_cnt = '0;
      if (len == 0) begin
        e_done = (k == 1);
      end else if (k < s) begin
        e_busy = 1'b1;
      end else begin
        j = k - s;
        e_cnt = (j >= total) ? 32'(len) : 32'(j / d_eff);
        if (j < total) begin
          e_busy = 1'b1;
          e_clk  = (j % d_eff) < (d_eff / 2);
          e_str  = (j % d_eff) == (d_eff - 1);
        end else if (j == total) begin
          e_done = 1'b1;
        end
      end
      e_oe = e_busy ? ~ch : 2'b11;
      chk($sformatf("%s k=%0d clk/strb/done/busy/oe", name, k),
          {bus.AD_clk, bus.sample_strobe, bus.done, bus.busy, bus.AD_OE_N},
          {e_clk, e_str, e_done, e_busy, e_oe});
      chk($sformatf("%s k=%0d sample_cnt", name, k), bus.sample_cnt, e_cnt);
    end
  endtask

  task automatic end_burst(input string name);
    chk({name, " held in QUIT"}, bus.dbg_state, QUIT);
    bus.burst_syn = 1'b0;
    tick();
    chk({name, " back to IDLE"}, bus.dbg_state, IDLE);
    tick();
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    reset_n = 1'b0;
    bus.burst_syn = 1'b0;
    bus.abort = 1'b0;
    bus.cfg_div = 8'd4;
    bus.cfg_len = 32'd8;
    bus.cfg_dly = 16'd0;
    bus.cfg_ch_en = 2'b11;
    repeat (3) tick();

    // reset values
    chk("reset outputs", {bus.AD_clk, bus.sample_strobe, bus.done, bus.busy, bus.AD_OE_N, bus.AD_PDWN},
        {1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 1'b0});
    chk("reset sample_cnt", bus.sample_cnt, 32'd0);
    chk("reset state", bus.dbg_state, IDLE);
    reset_n = 1'b1;

    // idle without trigger
    for (int k = 0; k < 10; k++) begin
      tick();
      chk($sformatf("idle k=%0d", k), {bus.AD_clk, bus.sample_strobe, bus.done, bus.busy, bus.AD_OE_N},
          {1'b0, 1'b0, 1'b0, 1'b0, 2'b11});
    end

    // basic burst, trigger held high well past done
    run_burst("basic", 4, 4, 8, 0, 2'b11, 50);
    end_burst("basic");

    // pre-sample delay with odd divide, one channel
    run_burst("dly_odd", 5, 5, 3, 10, 2'b01, 32);
    end_burst("dly_odd");

    // divider clamp
    run_burst("div0", 0, 2, 4, 0, 2'b10, 12);
    end_burst("div0");
    run_burst("div1", 1, 2, 4, 0, 2'b11, 12);
    end_burst("div1");

    // abort on the 6th strobe cycle: strobe suppressed, count stays at 5
    run_burst("abort", 4, 4, 100, 0, 2'b11, 23);
    tick();
    chk("abort pre strobe", bus.sample_strobe, 1'b1);
    bus.abort = 1'b1;
    #1;
    chk("abort strobe suppressed", bus.sample_strobe, 1'b0);
    tick();
    bus.abort = 1'b0;
    chk("abort done/clk/busy/oe", {bus.done, bus.AD_clk, bus.busy, bus.AD_OE_N}, {1'b1, 1'b0, 1'b0, 2'b11});
    chk("abort sample_cnt", bus.sample_cnt, 32'd5);
    tick();
    chk("abort done one cycle", bus.done, 1'b0);
    chk("abort sample_cnt hold", bus.sample_cnt, 32'd5);
    end_burst("abort");

    // zero length with a nonzero delay still goes straight to QUIT
    run_burst("len0", 4, 4, 0, 3, 2'b11, 6);
    end_burst("len0");

    // reset mid-burst
    run_burst("rst_mid", 4, 4, 8, 0, 2'b11, 6);
    reset_n = 1'b0;
    #1;
    chk("rst_mid outputs", {bus.AD_clk, bus.sample_strobe, bus.done, bus.busy, bus.AD_OE_N},
        {1'b0, 1'b0, 1'b0, 1'b0, 2'b11});
    chk("rst_mid sample_cnt", bus.sample_cnt, 32'd0);
    chk("rst_mid state", bus.dbg_state, IDLE);
    bus.burst_syn = 1'b0;
    tick();
    reset_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("rst_mid no done k=%0d", k), {bus.done, bus.busy}, 2'b00);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
